// File: rtl/lock_controller.sv
// -----------------------------------------------------------------------------
// lock_controller
//   Password-lock core state machine. Collects 2-bit key digits (one per
//   key_valid pulse), packs each digit into a nibble, compares a full entry
//   against the stored password and drives unlock / fail / alarm / password-
//   change status for the display stage.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   key_valid   1-cycle pulse, key_digit valid
//   key_digit   digit value 0..3
//   clear       1-cycle pulse, discard partial entry / abort password change
//   set_req     1-cycle pulse, request password change (honoured in OPEN only)
//   entry_data  digits entered so far, newest digit in the low nibble
//   entry_cnt   number of digits entered so far
//   unlocked    high in OPEN and SET
//   fail        1-cycle pulse on a wrong code
//   alarm       high in ALARM
//   set_done    1-cycle pulse when a new password has been stored
//   err_cnt     consecutive wrong entries
//   state       LOCKED=0 CHECK=1 OPEN=2 SET=3 ALARM=4
// -----------------------------------------------------------------------------
module lock_controller #(
  parameter int                  DIGITS     = 4,
  parameter logic [4*DIGITS-1:0] DEFAULT_PW = 16'h0123,
  parameter int                  MAX_ERR    = 3,
  parameter int                  UNLOCK_CYC = 1000,
  parameter int                  ALARM_CYC  = 5000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [1:0]            key_digit,
  input  logic                  clear,
  input  logic                  set_req,
  output logic [4*DIGITS-1:0]   entry_data,
  output logic [2:0]            entry_cnt,
  output logic                  unlocked,
  output logic                  fail,
  output logic                  alarm,
  output logic                  set_done,
  output logic [1:0]            err_cnt,
  output logic [2:0]            state
);

  localparam int W      = 4 * DIGITS;
  localparam int T_MAX  = (UNLOCK_CYC > ALARM_CYC) ? UNLOCK_CYC : ALARM_CYC;
  localparam int TW_RAW = $clog2(T_MAX);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYC - 1);
  localparam logic [TW-1:0] ALARM_LOAD  = TW'(ALARM_CYC - 1);
  localparam logic [2:0]    LAST_DIGIT  = 3'(DIGITS - 1);
  localparam logic [2:0]    ERR_LIMIT   = 3'(MAX_ERR);

  typedef enum logic [2:0] {
    S_LOCKED = 3'd0,
    S_CHECK  = 3'd1,
    S_OPEN   = 3'd2,
    S_SET    = 3'd3,
    S_ALARM  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  entry_q, entry_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    err_q, err_d;
  logic [W-1:0]  pw_q, pw_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          fail_q, fail_d;
  logic          set_done_q, set_done_d;
  logic          unlocked_q, unlocked_d;
  logic          alarm_q, alarm_d;

  // Entry with the incoming digit appended as a zero-extended nibble.
  logic [W-1:0]  entry_shifted;
  logic [2:0]    err_plus1;

  assign entry_shifted = {entry_q[W-5:0], 2'b00, key_digit};
  assign err_plus1     = {1'b0, err_q} + 3'd1;

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    pw_d       = pw_q;
    timer_d    = timer_q;
    fail_d     = 1'b0;
    set_done_d = 1'b0;

    case (state_q)
      S_LOCKED: begin
        // clear has priority over a digit arriving in the same cycle.
        if (clear) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (key_valid) begin
          entry_d = entry_shifted;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == LAST_DIGIT) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        if (entry_q == pw_q) begin
          err_d   = '0;
          timer_d = UNLOCK_LOAD;
          state_d = S_OPEN;
        end else if (err_plus1 < ERR_LIMIT) begin
          err_d   = err_plus1[1:0];
          fail_d  = 1'b1;
          state_d = S_LOCKED;
        end else begin
          // Final strike goes straight to ALARM without a fail pulse.
          err_d   = '0;
          timer_d = ALARM_LOAD;
          state_d = S_ALARM;
        end
      end

      S_OPEN: begin
        // set_req beats an expiring timer in the same cycle.
        if (set_req) begin
          timer_d = '0;
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_SET;
        end else if (timer_q == '0) begin
          state_d = S_LOCKED;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_SET: begin
        if (clear) begin
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_LOCKED;
        end else if (key_valid) begin
          if (cnt_q == LAST_DIGIT) begin
            pw_d       = entry_shifted;
            set_done_d = 1'b1;
            entry_d    = '0;
            cnt_d      = '0;
            state_d    = S_LOCKED;
          end else begin
            entry_d = entry_shifted;
            cnt_d   = cnt_q + 3'd1;
          end
        end
      end

      S_ALARM: begin
        if (timer_q == '0) begin
          state_d = S_LOCKED;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        entry_d = '0;
        cnt_d   = '0;
        timer_d = '0;
        state_d = S_LOCKED;
      end
    endcase

    // Status levels are registered from the next state so they line up
    // exactly with the state output.
    unlocked_d = (state_d == S_OPEN) || (state_d == S_SET);
    alarm_d    = (state_d == S_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOCKED;
      entry_q    <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      pw_q       <= DEFAULT_PW;
      timer_q    <= '0;
      fail_q     <= 1'b0;
      set_done_q <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      pw_q       <= pw_d;
      timer_q    <= timer_d;
      fail_q     <= fail_d;
      set_done_q <= set_done_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
    end
  end

  assign entry_data = entry_q;
  assign entry_cnt  = cnt_q;
  assign unlocked   = unlocked_q;
  assign fail       = fail_q;
  assign alarm      = alarm_q;
  assign set_done   = set_done_q;
  assign err_cnt    = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_lock_controller.sv
// -----------------------------------------------------------------------------
// tb_lock_controller
//   Directed self-checking bench for lock_controller with default parameters.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_lock_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [1:0]  key_digit = 2'd0;
  logic        clear = 1'b0;
  logic        set_req = 1'b0;
  logic [15:0] entry_data;
  logic [2:0]  entry_cnt;
  logic        unlocked;
  logic        fail;
  logic        alarm;
  logic        set_done;
  logic [1:0]  err_cnt;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] ST_LOCKED = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_OPEN   = 3'd2;
  localparam logic [2:0] ST_SET    = 3'd3;
  localparam logic [2:0] ST_ALARM  = 3'd4;

  lock_controller dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .clear      (clear),
    .set_req    (set_req),
    .entry_data (entry_data),
    .entry_cnt  (entry_cnt),
    .unlocked   (unlocked),
    .fail       (fail),
    .alarm      (alarm),
    .set_done   (set_done),
    .err_cnt    (err_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic press(input logic [1:0] d);
    @(negedge clk);
    key_valid = 1'b1;
    key_digit = d;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Code given as nibbles, first digit in the high nibble.
  task automatic enter_code(input logic [15:0] code);
    press(code[13:12]);
    press(code[9:8]);
    press(code[5:4]);
    press(code[1:0]);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulse_set();
    @(negedge clk);
    set_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
  endtask

  task automatic wait_locked();
    int n;
    n = 0;
    while (state != ST_LOCKED && n < 6000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (state !== ST_LOCKED) begin
      n_fail++;
      $display("FAIL wait_locked: state=%0d required %0d within 6000 cycles", state, ST_LOCKED);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({state, entry_data, entry_cnt, err_cnt, unlocked, fail, alarm, set_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0d entry=%h cnt=%0d err=%0d unl=%b fail=%b alarm=%b sd=%b required all zero",
               state, entry_data, entry_cnt, err_cnt, unlocked, fail, alarm, set_done);
    end
    $display("test_reset done");
  endtask

  task automatic test_unlock();
    int cnt;
    enter_code(16'h0123);
    n_checks++;
    if (state !== ST_CHECK || entry_data !== 16'h0123) begin
      n_fail++;
      $display("FAIL unlock_check_state: state=%0d entry=%h required %0d / 0123", state, entry_data, ST_CHECK);
    end
    @(negedge clk);
    n_checks++;
    if (unlocked !== 1'b1 || state !== ST_OPEN || entry_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL unlock_open: unl=%b state=%0d cnt=%0d required 1/%0d/0", unlocked, state, entry_cnt, ST_OPEN);
    end
    cnt = 0;
    while (unlocked === 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != 1000 || state !== ST_LOCKED) begin
      n_fail++;
      $display("FAIL unlock_duration: cycles=%0d state=%0d required 1000/%0d", cnt, state, ST_LOCKED);
    end
    $display("test_unlock done: unlocked for %0d cycles", cnt);
  endtask

  task automatic test_wrong_alarm();
    int cnt;
    for (int i = 1; i <= 2; i++) begin
      enter_code(16'h3333);
      @(negedge clk);
      n_checks++;
      if (fail !== 1'b1 || err_cnt !== 2'(i) || state !== ST_LOCKED) begin
        n_fail++;
        $display("FAIL wrong_%0d: fail=%b err=%0d state=%0d required 1/%0d/%0d", i, fail, err_cnt, state, i, ST_LOCKED);
      end
      @(negedge clk);
      n_checks++;
      if (fail !== 1'b0) begin
        n_fail++;
        $display("FAIL wrong_%0d_pulse: fail=%b required 0", i, fail);
      end
    end
    enter_code(16'h3333);
    @(negedge clk);
    n_checks++;
    if (alarm !== 1'b1 || fail !== 1'b0 || err_cnt !== 2'd0 || state !== ST_ALARM) begin
      n_fail++;
      $display("FAIL alarm_enter: alarm=%b fail=%b err=%0d state=%0d required 1/0/0/%0d", alarm, fail, err_cnt, state, ST_ALARM);
    end
    cnt = 0;
    while (alarm === 1'b1 && cnt < 6000) begin
      cnt++;
      key_valid = (cnt <= 4);
      key_digit = 2'd1;
      clear     = (cnt == 6);
      @(negedge clk);
      if (cnt == 5) begin
        n_checks++;
        if (entry_cnt !== 3'd0 || state !== ST_ALARM) begin
          n_fail++;
          $display("FAIL alarm_keys_ignored: cnt=%0d state=%0d required 0/%0d", entry_cnt, state, ST_ALARM);
        end
      end
    end
    key_valid = 1'b0;
    clear     = 1'b0;
    n_checks++;
    if (cnt != 5000 || state !== ST_LOCKED || entry_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL alarm_duration: cycles=%0d state=%0d cnt=%0d required 5000/%0d/0", cnt, state, entry_cnt, ST_LOCKED);
    end
    $display("test_wrong_alarm done: alarm for %0d cycles", cnt);
  endtask

  task automatic test_clear();
    press(2'd1);
    press(2'd2);
    n_checks++;
    if (entry_cnt !== 3'd2 || entry_data !== 16'h0012) begin
      n_fail++;
      $display("FAIL partial_entry: cnt=%0d entry=%h required 2/0012", entry_cnt, entry_data);
    end
    pulse_clear();
    n_checks++;
    if (entry_cnt !== 3'd0 || entry_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_entry: cnt=%0d entry=%h required 0/0000", entry_cnt, entry_data);
    end
    enter_code(16'h0123);
    @(negedge clk);
    n_checks++;
    if (unlocked !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_then_unlock: unl=%b required 1", unlocked);
    end
    wait_locked();
    press(2'd3);
    @(negedge clk);
    clear     = 1'b1;
    key_valid = 1'b1;
    key_digit = 2'd2;
    @(negedge clk);
    clear     = 1'b0;
    key_valid = 1'b0;
    n_checks++;
    if (entry_cnt !== 3'd0 || entry_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_and_key: cnt=%0d entry=%h required 0/0000", entry_cnt, entry_data);
    end
    $display("test_clear done");
  endtask

  task automatic test_set_password();
    enter_code(16'h0123);
    @(negedge clk);
    pulse_set();
    n_checks++;
    if (state !== ST_SET || unlocked !== 1'b1) begin
      n_fail++;
      $display("FAIL set_enter: state=%0d unl=%b required %0d/1", state, unlocked, ST_SET);
    end
    enter_code(16'h2210);
    n_checks++;
    if (set_done !== 1'b1 || state !== ST_LOCKED || entry_cnt !== 3'd0 || unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL set_done: sd=%b state=%0d cnt=%0d unl=%b required 1/%0d/0/0", set_done, state, entry_cnt, unlocked, ST_LOCKED);
    end
    @(negedge clk);
    n_checks++;
    if (set_done !== 1'b0) begin
      n_fail++;
      $display("FAIL set_done_pulse: sd=%b required 0", set_done);
    end
    enter_code(16'h0123);
    @(negedge clk);
    n_checks++;
    if (fail !== 1'b1 || unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL old_pw_rejected: fail=%b unl=%b required 1/0", fail, unlocked);
    end
    enter_code(16'h2210);
    @(negedge clk);
    n_checks++;
    if (unlocked !== 1'b1 || err_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL new_pw_accepted: unl=%b err=%0d required 1/0", unlocked, err_cnt);
    end
    wait_locked();
    $display("test_set_password done");
  endtask

  task automatic test_set_abort();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    enter_code(16'h0123);
    @(negedge clk);
    pulse_set();
    press(2'd1);
    press(2'd1);
    pulse_clear();
    n_checks++;
    if (state !== ST_LOCKED || unlocked !== 1'b0 || set_done !== 1'b0 || entry_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL set_abort: state=%0d unl=%b sd=%b cnt=%0d required %0d/0/0/0", state, unlocked, set_done, entry_cnt, ST_LOCKED);
    end
    enter_code(16'h0123);
    @(negedge clk);
    n_checks++;
    if (unlocked !== 1'b1) begin
      n_fail++;
      $display("FAIL pw_unchanged: unl=%b required 1", unlocked);
    end
    wait_locked();
    $display("test_set_abort done");
  endtask

  task automatic test_reset_and_timeout();
    enter_code(16'h0123);
    @(negedge clk);
    pulse_set();
    enter_code(16'h3210);
    enter_code(16'h0000);
    @(negedge clk);
    enter_code(16'h0000);
    @(negedge clk);
    n_checks++;
    if (err_cnt !== 2'd2) begin
      n_fail++;
      $display("FAIL pre_reset_err: err=%0d required 2", err_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({state, entry_data, entry_cnt, err_cnt, unlocked, fail, alarm, set_done} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: state=%0d entry=%h cnt=%0d err=%0d unl=%b fail=%b alarm=%b sd=%b required all zero",
               state, entry_data, entry_cnt, err_cnt, unlocked, fail, alarm, set_done);
    end
    enter_code(16'h0123);
    @(negedge clk);
    n_checks++;
    if (unlocked !== 1'b1) begin
      n_fail++;
      $display("FAIL default_pw_restored: unl=%b required 1", unlocked);
    end
    // Advance to the last OPEN cycle (timer at 0), then request SET.
    repeat (999) @(negedge clk);
    n_checks++;
    if (state !== ST_OPEN) begin
      n_fail++;
      $display("FAIL open_last_cycle: state=%0d required %0d", state, ST_OPEN);
    end
    set_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
    n_checks++;
    if (state !== ST_SET || unlocked !== 1'b1) begin
      n_fail++;
      $display("FAIL set_beats_timeout: state=%0d unl=%b required %0d/1", state, unlocked, ST_SET);
    end
    pulse_clear();
    n_checks++;
    if (state !== ST_LOCKED) begin
      n_fail++;
      $display("FAIL set_exit: state=%0d required %0d", state, ST_LOCKED);
    end
    $display("test_reset_and_timeout done");
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong_alarm();
    test_clear();
    test_set_password();
    test_set_abort();
    test_reset_and_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
